// File: rtl/kfps2kb_command_sequencer.sv
// ============================================================================
// Module      : kfps2kb_command_sequencer
// Description : Host-to-keyboard PS/2 command scheduler. Arbitrates keyboard
//               reset, LED update and generic command requests, drives the
//               transmitter and consumes FA/FE/AA/FC replies.
//               Optional feature macro: KFPS2KB_POWERUP_RESET_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kfps2kb_command_sequencer #(
    parameter logic [15:0] ACK_TIMEOUT = 16'd50000,
    parameter logic [23:0] BAT_TIMEOUT = 24'd800000,
    parameter int          MAX_RETRY   = 2
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    input  logic       tx_ready_i,
    input  logic       tx_done_i,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    input  logic       kbd_rst_req_i,
    input  logic       led_req_i,
    input  logic [2:0] led_state_i,
    input  logic       cmd_req_i,
    input  logic [7:0] cmd_byte_i,
    output logic [2:0] grant_o,
    output logic       rx_consume_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] C_RETRY_LIM = RETRY_W'(MAX_RETRY);
    localparam logic [23:0] C_ACK_LAST = {8'd0, ACK_TIMEOUT} - 24'd1;
    localparam logic [23:0] C_BAT_LAST = BAT_TIMEOUT - 24'd1;

    localparam logic [7:0] C_BYTE_ACK    = 8'hFA;
    localparam logic [7:0] C_BYTE_RESEND = 8'hFE;
    localparam logic [7:0] C_BYTE_BAT_OK = 8'hAA;
    localparam logic [7:0] C_BYTE_BAT_NG = 8'hFC;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND     = 3'd1,
        S_WAIT_TX  = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_WAIT_BAT = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        K_RST = 2'd0,
        K_LED = 2'd1,
        K_CMD = 2'd2
    } kind_t;

    state_t               state_q, state_d;
    kind_t                kind_q, kind_d;
    logic                 idx_q, idx_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [7:0]           led_byte_q, led_byte_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [23:0]          cnt_q, cnt_d;
    logic [2:0]           grant_q, grant_d;
    logic                 w_consume;
    logic                 w_pend;
    logic                 w_rst_any;
    logic [23:0]          w_cnt_inc;

`ifdef KFPS2KB_POWERUP_RESET_EN
    // One-shot internal reset request, raised by reset and retired when granted.
    logic pend_q;
    logic pend_d;

    always_comb begin
        pend_d = pend_q && (state_q != S_IDLE);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pend_q <= 1'b1;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign w_pend = pend_q;
`else
    assign w_pend = 1'b0;
`endif

    assign w_rst_any = kbd_rst_req_i | w_pend;
    assign w_cnt_inc = (cnt_q == 24'hFF_FFFF) ? cnt_q : cnt_q + 24'd1;

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        led_byte_d = led_byte_q;
        retry_d    = retry_q;
        cnt_d      = cnt_q;
        grant_d    = 3'b000;
        w_consume  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_rst_any) begin
                    state_d   = S_SEND;
                    kind_d    = K_RST;
                    tx_data_d = 8'hFF;
                    grant_d   = {2'b00, kbd_rst_req_i};
                    idx_d     = 1'b0;
                    retry_d   = '0;
                end else if (led_req_i) begin
                    state_d    = S_SEND;
                    kind_d     = K_LED;
                    tx_data_d  = 8'hED;
                    led_byte_d = {5'b00000, led_state_i};
                    grant_d    = 3'b010;
                    idx_d      = 1'b0;
                    retry_d    = '0;
                end else if (cmd_req_i) begin
                    state_d   = S_SEND;
                    kind_d    = K_CMD;
                    tx_data_d = cmd_byte_i;
                    grant_d   = 3'b100;
                    idx_d     = 1'b0;
                    retry_d   = '0;
                end
            end
            S_SEND: begin
                if (tx_ready_i) begin
                    state_d = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (tx_done_i) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // Reply bytes take precedence over a timeout expiring the same cycle.
                if (rx_valid_i && (rx_data_i == C_BYTE_ACK)) begin
                    w_consume = 1'b1;
                    retry_d   = '0;
                    if ((kind_q == K_LED) && !idx_q) begin
                        idx_d     = 1'b1;
                        tx_data_d = led_byte_q;
                        state_d   = S_SEND;
                    end else if (kind_q == K_RST) begin
                        cnt_d   = '0;
                        state_d = S_WAIT_BAT;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (rx_valid_i && (rx_data_i == C_BYTE_RESEND)) begin
                    w_consume = 1'b1;
                    if (retry_q < C_RETRY_LIM) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_SEND;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (w_cnt_inc == C_ACK_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            S_WAIT_BAT: begin
                if (rx_valid_i && (rx_data_i == C_BYTE_BAT_OK)) begin
                    w_consume = 1'b1;
                    state_d   = S_DONE;
                end else if (rx_valid_i && (rx_data_i == C_BYTE_BAT_NG)) begin
                    w_consume = 1'b1;
                    state_d   = S_ERR;
                end else if (w_cnt_inc == C_BAT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            kind_q     <= K_CMD;
            idx_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            led_byte_q <= 8'h00;
            retry_q    <= '0;
            cnt_q      <= '0;
            grant_q    <= 3'b000;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            led_byte_q <= led_byte_d;
            retry_q    <= retry_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
        end
    end

    assign tx_valid_o   = (state_q == S_SEND);
    assign tx_data_o    = tx_data_q;
    assign grant_o      = grant_q;
    assign rx_consume_o = w_consume & ~reset_i;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign error_o      = (state_q == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_kfps2kb_command_sequencer.sv
// ============================================================================
// Module      : tb_kfps2kb_command_sequencer
// Description : Cycle vector table plus directed timing sequences for the
//               PS/2 command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kfps2kb_command_sequencer;

    localparam logic [15:0] C_ACK = 16'd20;
    localparam logic [23:0] C_BAT = 24'd30;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       kbd_rst_req;
    logic       led_req;
    logic [2:0] led_state;
    logic       cmd_req;
    logic [7:0] cmd_byte;
    logic [2:0] grant;
    logic       rx_consume;
    logic       busy;
    logic       done;
    logic       error;

    kfps2kb_command_sequencer #(
        .ACK_TIMEOUT (C_ACK),
        .BAT_TIMEOUT (C_BAT),
        .MAX_RETRY   (2)
    ) u_dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .tx_ready_i   (tx_ready),
        .tx_done_i    (tx_done),
        .tx_valid_o   (tx_valid),
        .tx_data_o    (tx_data),
        .kbd_rst_req_i(kbd_rst_req),
        .led_req_i    (led_req),
        .led_state_i  (led_state),
        .cmd_req_i    (cmd_req),
        .cmd_byte_i   (cmd_byte),
        .grant_o      (grant),
        .rx_consume_o (rx_consume),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    // req = {rst,kbd,led,cmd}; bus = {tx_ready,tx_done,rx_valid}; fl = {rx_consume,busy,done,error}
    typedef struct packed {
        logic [3:0] req;
        logic [2:0] ls;
        logic [7:0] cb;
        logic [2:0] bus;
        logic [7:0] rxd;
        logic       tv;
        logic [7:0] td;
        logic [2:0] gr;
        logic [3:0] fl;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nmis = 0;

    function automatic void add(input logic [3:0] req, input logic [2:0] ls, input logic [7:0] cb,
                                input logic [2:0] bus, input logic [7:0] rxd, input logic tv,
                                input logic [7:0] td, input logic [2:0] gr, input logic [3:0] fl);
        vec_t v;
        v.req = req; v.ls = ls; v.cb = cb; v.bus = bus; v.rxd = rxd;
        v.tv = tv; v.td = td; v.gr = gr; v.fl = fl;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; tx_done = 1'b0;
        kbd_rst_req = 1'b0; led_req = 1'b0; led_state = 3'b000; cmd_req = 1'b0; cmd_byte = 8'h00;

        // LED update ED,05 with a stray scancode while waiting for the first ack
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'h00, 3'b000, 4'b0000);
        add(4'b0010, 3'd5, 8'h00, 3'b000, 8'h00, 1'b0, 8'h00, 3'b000, 4'b0000);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b1, 8'hED, 3'b010, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b100, 8'h00, 1'b1, 8'hED, 3'b000, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hED, 3'b000, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b010, 8'h00, 1'b0, 8'hED, 3'b000, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b001, 8'h1C, 1'b0, 8'hED, 3'b000, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b001, 8'hFA, 1'b0, 8'hED, 3'b000, 4'b1100);
        add(4'b0000, 3'd0, 8'h00, 3'b100, 8'h00, 1'b1, 8'h05, 3'b000, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b010, 8'h00, 1'b0, 8'h05, 3'b000, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b001, 8'hFA, 1'b0, 8'h05, 3'b000, 4'b1100);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'h05, 3'b000, 4'b0110);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'h05, 3'b000, 4'b0000);

        // Command F4 answered FE, FE, FA
        add(4'b0001, 3'd0, 8'hF4, 3'b000, 8'h00, 1'b0, 8'h05, 3'b000, 4'b0000);
        for (int r = 0; r < 3; r++) begin
            add(4'b0000, 3'd0, 8'h00, 3'b100, 8'h00, 1'b1, 8'hF4, (r == 0) ? 3'b100 : 3'b000, 4'b0100);
            add(4'b0000, 3'd0, 8'h00, 3'b010, 8'h00, 1'b0, 8'hF4, 3'b000, 4'b0100);
            add(4'b0000, 3'd0, 8'h00, 3'b001, (r == 2) ? 8'hFA : 8'hFE, 1'b0, 8'hF4, 3'b000, 4'b1100);
        end
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hF4, 3'b000, 4'b0110);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hF4, 3'b000, 4'b0000);

        // Command AB answered FE three times: retry limit exhausted
        add(4'b0001, 3'd0, 8'hAB, 3'b000, 8'h00, 1'b0, 8'hF4, 3'b000, 4'b0000);
        for (int r = 0; r < 3; r++) begin
            add(4'b0000, 3'd0, 8'h00, 3'b100, 8'h00, 1'b1, 8'hAB, (r == 0) ? 3'b100 : 3'b000, 4'b0100);
            add(4'b0000, 3'd0, 8'h00, 3'b010, 8'h00, 1'b0, 8'hAB, 3'b000, 4'b0100);
            add(4'b0000, 3'd0, 8'h00, 3'b001, 8'hFE, 1'b0, 8'hAB, 3'b000, 4'b1100);
        end
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hAB, 3'b000, 4'b0101);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hAB, 3'b000, 4'b0000);

        // Keyboard reset: FF, FA, scancode, AA -> done; then FF, FA, FC -> error
        add(4'b0100, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hAB, 3'b000, 4'b0000);
        add(4'b0000, 3'd0, 8'h00, 3'b100, 8'h00, 1'b1, 8'hFF, 3'b001, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b010, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b001, 8'hFA, 1'b0, 8'hFF, 3'b000, 4'b1100);
        add(4'b0000, 3'd0, 8'h00, 3'b001, 8'h1C, 1'b0, 8'hFF, 3'b000, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b001, 8'hAA, 1'b0, 8'hFF, 3'b000, 4'b1100);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0110);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0000);
        add(4'b0100, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0000);
        add(4'b0000, 3'd0, 8'h00, 3'b100, 8'h00, 1'b1, 8'hFF, 3'b001, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b010, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b001, 8'hFA, 1'b0, 8'hFF, 3'b000, 4'b1100);
        add(4'b0000, 3'd0, 8'h00, 3'b001, 8'hFC, 1'b0, 8'hFF, 3'b000, 4'b1100);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0101);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0000);

        // All three requests at once: reset wins; no reply -> error ACK cycles after tx_done
        add(4'b0111, 3'd3, 8'h12, 3'b000, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0000);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b1, 8'hFF, 3'b001, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b100, 8'h00, 1'b1, 8'hFF, 3'b000, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b010, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0100);
        for (int k = 1; k < int'(C_ACK); k++) begin
            add(4'b0000, 3'd0, 8'h00, (k == 5) ? 3'b001 : 3'b000, 8'h1C, 1'b0, 8'hFF, 3'b000, 4'b0100);
        end
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0101);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0000);

        // Self-test never reported -> error BAT cycles after the FA
        add(4'b0100, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0000);
        add(4'b0000, 3'd0, 8'h00, 3'b100, 8'h00, 1'b1, 8'hFF, 3'b001, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b010, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b001, 8'hFA, 1'b0, 8'hFF, 3'b000, 4'b1100);
        for (int k = 1; k < int'(C_BAT); k++) begin
            add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0100);
        end
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0101);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0000);

        // Reset while waiting for an ack, with an FA arriving that same cycle
        add(4'b0001, 3'd0, 8'h3C, 3'b000, 8'h00, 1'b0, 8'hFF, 3'b000, 4'b0000);
        add(4'b0000, 3'd0, 8'h00, 3'b100, 8'h00, 1'b1, 8'h3C, 3'b100, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b010, 8'h00, 1'b0, 8'h3C, 3'b000, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'h3C, 3'b000, 4'b0100);
        add(4'b1000, 3'd0, 8'h00, 3'b001, 8'hFA, 1'b0, 8'h3C, 3'b000, 4'b0100);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'h00, 3'b000, 4'b0000);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'h00, 3'b000, 4'b0000);
        add(4'b0000, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 8'h00, 3'b000, 4'b0000);

        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            {rst, kbd_rst_req, led_req, cmd_req} = tbl[i].req;
            led_state = tbl[i].ls;
            cmd_byte  = tbl[i].cb;
            {tx_ready, tx_done, rx_valid} = tbl[i].bus;
            rx_data   = tbl[i].rxd;
            #1;
            nvec++;
            if ({tx_valid, tx_data, grant, rx_consume, busy, done, error} !==
                {tbl[i].tv, tbl[i].td, tbl[i].gr, tbl[i].fl}) begin
                nmis++;
                $display("FAIL vec%0d: got tv=%b td=%h gr=%b rc/bz/dn/er=%b, expected tv=%b td=%h gr=%b rc/bz/dn/er=%b",
                         i, tx_valid, tx_data, grant, {rx_consume, busy, done, error},
                         tbl[i].tv, tbl[i].td, tbl[i].gr, tbl[i].fl);
            end
        end

        // Directed: measure the ack timeout latency from the tx_done cycle
        @(negedge clk);
        rst = 1'b0; tx_ready = 1'b0; tx_done = 1'b0; rx_valid = 1'b0;
        cmd_req = 1'b1; cmd_byte = 8'h42;
        @(negedge clk);
        cmd_req = 1'b0;
        n = 0;
        while (!tx_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("offer_cmd_42", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h42});
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        tx_done  = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        n = 1;
        while (!error && n < int'(C_ACK) + 10) begin
            @(negedge clk);
            n++;
        end
        check("ack_timeout_latency", n, int'(C_ACK));
        @(negedge clk);
        check("busy_after_error", {31'd0, busy}, 32'd0);

        // Directed: behaviour right after a fresh reset
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`ifdef KFPS2KB_POWERUP_RESET_EN
        check("powerup_auto_ff", {20'd0, tx_valid, tx_data, grant}, {20'd0, 1'b1, 8'hFF, 3'b000});
`else
        check("no_auto_request", {20'd0, tx_valid, tx_data, grant}, {20'd0, 1'b0, 8'h00, 3'b000});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

`default_nettype wire
